prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 164 ++++++++++++++++
 tb/tb_prog_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Streaming program loader: receives a length-prefixed, XOR-checksummed byte stream,
// assembles little-endian 32-bit words, writes them to instruction memory and then releases the CPU from reset.
module prog_loader (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        CPUReset,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  WordsLoaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  words_loaded_q, words_loaded_d;

  logic accept;
  logic load_start;

  // Status outputs are pure decodes of the state, so they switch in the same cycle as the state.
  always_comb begin
    ByteReady = 1'b0;
    MemWE     = 1'b0;
    CPUReset  = 1'b1;
    Done      = 1'b0;
    Error     = 1'b0;
    case (state_q)
      S_HDR, S_DATA, S_CHK: ByteReady = 1'b1;
      S_WRITE:              MemWE     = 1'b1;
      S_DONE: begin
        CPUReset = 1'b0;
        Done     = 1'b1;
      end
      S_ERR:                Error     = 1'b1;
      default: ;
    endcase
  end

  assign accept      = ByteValid & ByteReady;
  assign MemAddr     = mem_addr_q;
  assign MemWData    = mem_wdata_q;
  assign WordsLoaded = words_loaded_q;

  // Start is honoured only while waiting: in IDLE or after a finished load.
  assign load_start = Start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a value unassigned (no latches).
    state_d        = state_q;
    n_d            = n_q;
    word_idx_d     = word_idx_q;
    byte_idx_d     = byte_idx_q;
    acc_d          = acc_q;
    word_buf_d     = word_buf_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    words_loaded_d = words_loaded_q;

    if (load_start) begin
      state_d        = S_HDR;
      word_idx_d     = 8'd0;
      byte_idx_d     = 2'd0;
      acc_d          = 8'd0;
      word_buf_d     = 24'd0;
      words_loaded_d = 8'd0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (accept) begin
            if (ByteIn == 8'd0) begin
              state_d = S_ERR;
            end else begin
              n_d     = ByteIn;
              state_d = S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            acc_d      = acc_q ^ ByteIn;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_buf_d[7:0]   = ByteIn;
              2'd1: word_buf_d[15:8]  = ByteIn;
              2'd2: word_buf_d[23:16] = ByteIn;
              2'd3: begin
                // The full word is published only on completion, so a partial word never reaches MemWData.
                mem_wdata_d = {ByteIn, word_buf_q};
                mem_addr_d  = {22'd0, word_idx_q, 2'b00};
                state_d     = S_WRITE;
              end
              default: ;
            endcase
          end
        end

        S_WRITE: begin
          word_idx_d     = word_idx_q + 8'd1;
          words_loaded_d = words_loaded_q + 8'd1;
          if ((word_idx_q + 8'd1) == n_q) state_d = S_CHK;
          else                            state_d = S_DATA;
        end

        S_CHK: begin
          if (accept) begin
            if (ByteIn == acc_q) state_d = S_DONE;
            else                 state_d = S_ERR;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      n_q            <= 8'd0;
      word_idx_q     <= 8'd0;
      byte_idx_q     <= 2'd0;
      acc_q          <= 8'd0;
      word_buf_q     <= 24'd0;
      mem_addr_q     <= 32'd0;
      mem_wdata_q    <= 32'd0;
      words_loaded_q <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q        <= state_d;
      n_q            <= n_d;
      word_idx_q     <= word_idx_d;
      byte_idx_q     <= byte_idx_d;
      acc_q          <= acc_d;
      word_buf_q     <= word_buf_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      words_loaded_q <= words_loaded_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a table of complete load streams with expected results,
// plus hand-written sequences for Start-during-load and reset-mid-load.
module tb_prog_loader;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        CPUReset;
  logic        Done;
  logic        Error;
  logic [7:0]  WordsLoaded;

  prog_loader dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .ByteIn     (ByteIn),
    .ByteValid  (ByteValid),
    .ByteReady  (ByteReady),
    .MemWE      (MemWE),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .CPUReset   (CPUReset),
    .Done       (Done),
    .Error      (Error),
    .WordsLoaded(WordsLoaded)
  );

  always #5 Clock = ~Clock;

  int total    = 0;
  int bad      = 0;
  int we_count = 0;

  typedef struct {
    logic [7:0]  hdr;        // word count N; 0 means no payload or checksum is sent
    logic [31:0] w [4];      // payload words, sent little-endian
    logic [7:0]  chk;        // checksum byte sent
    bit          gaps;       // randomly deassert ByteValid between bytes
    bit          exp_done;   // 1: Done expected, 0: Error expected
    logic [7:0]  exp_words;  // expected WordsLoaded and MemWE pulse count
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every write pulse is counted, and ByteReady must be low while it is high.
  always @(negedge Clock) begin
    if (MemWE === 1'b1) begin
      we_count++;
      check("ready_in_write", 32'(ByteReady), 32'd0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called on a falling edge; returns on the falling edge just after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    int budget;
    if (gaps) begin
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        ByteValid = 1'b0;
        ByteIn    = 8'($urandom);
        @(negedge Clock);
      end
    end
    ByteIn    = b;
    ByteValid = 1'b1;
    budget    = 0;
    while (ByteReady !== 1'b1 && budget < 20) begin
      @(negedge Clock);
      budget++;
    end
    if (ByteReady !== 1'b1) check("ready_timeout", 32'(ByteReady), 32'd1);
    @(negedge Clock);
    ByteValid = 1'b0;
    ByteIn    = 8'($urandom);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    logic [31:0] word;
    int          we0;
    v = vecs[idx];
    pulse_start();
    check($sformatf("v%0d_hdr_cpureset", idx), 32'(CPUReset), 32'd1);
    check($sformatf("v%0d_hdr_done", idx), 32'(Done), 32'd0);
    check($sformatf("v%0d_hdr_error", idx), 32'(Error), 32'd0);
    check($sformatf("v%0d_hdr_words", idx), 32'(WordsLoaded), 32'd0);
    we0 = we_count;
    send_byte(v.hdr, v.gaps);
    if (v.hdr != 8'd0) begin
      for (int wi = 0; wi < int'(v.hdr); wi++) begin
        word = v.w[wi];
        for (int k = 0; k < 4; k++) send_byte(word[8*k +: 8], v.gaps);
        check($sformatf("v%0d_w%0d_we", idx, wi), 32'(MemWE), 32'd1);
        check($sformatf("v%0d_w%0d_addr", idx, wi), MemAddr, 32'(wi * 4));
        check($sformatf("v%0d_w%0d_data", idx, wi), MemWData, word);
      end
      send_byte(v.chk, v.gaps);
    end
    check($sformatf("v%0d_done", idx), 32'(Done), 32'(v.exp_done));
    check($sformatf("v%0d_error", idx), 32'(Error), 32'(!v.exp_done));
    check($sformatf("v%0d_cpureset", idx), 32'(CPUReset), 32'(!v.exp_done));
    check($sformatf("v%0d_words", idx), 32'(WordsLoaded), 32'(v.exp_words));
    check($sformatf("v%0d_we_pulses", idx), 32'(we_count - we0), 32'(v.exp_words));
    repeat (2) @(negedge Clock);
    check($sformatf("v%0d_we_idle", idx), 32'(MemWE), 32'd0);
    check($sformatf("v%0d_done_hold", idx), 32'(Done), 32'(v.exp_done));
    if (v.exp_words != 8'd0) begin
      check($sformatf("v%0d_addr_hold", idx), MemAddr, 32'((int'(v.exp_words) - 1) * 4));
      check($sformatf("v%0d_data_hold", idx), MemWData, v.w[int'(v.exp_words) - 1]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ByteReady), 32'd0);
    check({tag, "_we"}, 32'(MemWE), 32'd0);
    check({tag, "_addr"}, MemAddr, 32'd0);
    check({tag, "_wdata"}, MemWData, 32'd0);
    check({tag, "_cpureset"}, 32'(CPUReset), 32'd1);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_error"}, 32'(Error), 32'd0);
    check({tag, "_words"}, 32'(WordsLoaded), 32'd0);
  endtask

  initial begin
    int we0;

    // Checksums are hand-computed XORs of all payload bytes.
    vecs[0] = '{8'h01, '{32'h12345678, 32'h0, 32'h0, 32'h0}, 8'h08, 1'b0, 1'b1, 8'd1};
    vecs[1] = '{8'h02, '{32'hE3A00001, 32'hE2800002, 32'h0, 32'h0}, 8'h22, 1'b0, 1'b1, 8'd2};
    vecs[2] = '{8'h01, '{32'h12345678, 32'h0, 32'h0, 32'h0}, 8'h09, 1'b0, 1'b0, 8'd1};
    vecs[3] = '{8'h00, '{32'h0, 32'h0, 32'h0, 32'h0}, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[4] = '{8'h02, '{32'hE3A00001, 32'hE2800002, 32'h0, 32'h0}, 8'h22, 1'b1, 1'b1, 8'd2};
    vecs[5] = '{8'h03, '{32'h00000000, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h0}, 8'h00, 1'b0, 1'b1, 8'd3};

    Reset     = 1'b1;
    Start     = 1'b0;
    ByteValid = 1'b0;
    ByteIn    = 8'h00;
    repeat (3) @(negedge Clock);
    check_reset_outputs("por");
    Reset = 1'b0;
    ByteValid = 1'b1;
    @(negedge Clock);
    check("idle_ready", 32'(ByteReady), 32'd0);
    check("idle_cpureset", 32'(CPUReset), 32'd1);
    ByteValid = 1'b0;

    // Start pulsed in the middle of a word must not restart the load.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h78, 1'b0);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    check("midstart_we", 32'(MemWE), 32'd1);
    check("midstart_data", MemWData, 32'h12345678);
    send_byte(8'h08, 1'b0);
    check("midstart_done", 32'(Done), 32'd1);
    check("midstart_words", 32'(WordsLoaded), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset after two payload bytes, with Start and a valid byte in the same cycle.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    we0       = we_count;
    ByteIn    = 8'h34;
    ByteValid = 1'b1;
    Start     = 1'b1;
    Reset     = 1'b1;
    @(negedge Clock);
    check_reset_outputs("midrst");
    Reset     = 1'b0;
    Start     = 1'b0;
    ByteIn    = 8'h12;
    @(negedge Clock);
    check("postrst_ready", 32'(ByteReady), 32'd0);
    check("postrst_we", 32'(MemWE), 32'd0);
    check("postrst_cpureset", 32'(CPUReset), 32'd1);
    check("postrst_we_pulses", 32'(we_count - we0), 32'd0);
    ByteValid = 1'b0;
    @(negedge Clock);

    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
